multicycle_core: RTL and testbench

MULTICYCLE_CORE -- requirements
Module: multicycle_core

---
 rtl/multicycle_core.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_core.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
// Multicycle core: one shared memory port, one FSM state per memory access.
// Memory-side outputs are registered; the register file resets to zero.
module multicycle_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              halted,
    output logic              illegal
);
    localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [5:0] OP_AND   = 6'b000000;
    localparam logic [5:0] OP_OR    = 6'b000001;
    localparam logic [5:0] OP_NOT   = 6'b000010;
    localparam logic [5:0] OP_XOR   = 6'b000011;
    localparam logic [5:0] OP_ADDU  = 6'b000100;
    localparam logic [5:0] OP_SUBU  = 6'b000110;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] OP_JMP   = 6'b100000;
    localparam logic [5:0] OP_BEQZ  = 6'b100001;
    localparam logic [5:0] OP_LOAD  = 6'b100100;
    localparam logic [5:0] OP_LDI   = 6'b101000;
    localparam logic [5:0] OP_STORE = 6'b101100;

    typedef enum logic [2:0] {
        S_FETCH1, S_FETCH2, S_EXEC, S_MEMRD, S_MEMWR, S_HALT
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic              halted_q;
    logic              illegal_q;
    logic [5:0]        op_q;
    logic [RIDX_W-1:0] rd_q;
    logic [RIDX_W-1:0] rs_q;
    logic [DATA_W-1:0] regs_q [NREGS];

    logic [5:0]        f_op;
    logic [RIDX_W-1:0] f_rd;
    logic [RIDX_W-1:0] f_rs;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] imm_addr;
    logic [ADDR_W-1:0] br_addr;
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] alu_res;
    logic              done;

    always_comb begin
        f_op     = mem_rdata[15:10];
        f_rd     = mem_rdata[5 +: RIDX_W];
        f_rs     = mem_rdata[0 +: RIDX_W];
        pc_inc   = pc_q + ADDR_W'(1);
        imm_addr = mem_rdata[ADDR_W-1:0];
        rd_val   = regs_q[rd_q];
        rs_val   = regs_q[rs_q];
        br_addr  = (rd_val == '0) ? imm_addr : pc_inc;
        done     = mem_req_q & mem_ready;
        case (op_q)
            OP_AND:  alu_res = rd_val & rs_val;
            OP_OR:   alu_res = rd_val | rs_val;
            OP_NOT:  alu_res = ~rs_val;
            OP_XOR:  alu_res = rd_val ^ rs_val;
            OP_ADDU: alu_res = rd_val + rs_val;
            default: alu_res = rd_val - rs_val;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH1;
            pc_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
            op_q        <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                S_FETCH1: begin
                    // Out of reset the request is not yet on the bus; raise it first.
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                    end else if (mem_ready) begin
                        op_q <= f_op;
                        rd_q <= f_rd;
                        rs_q <= f_rs;
                        pc_q <= pc_inc;
                        case (f_op)
                            OP_AND, OP_OR, OP_NOT, OP_XOR, OP_ADDU, OP_SUBU: begin
                                state_q   <= S_EXEC;
                                mem_req_q <= 1'b0;
                            end
                            OP_HALT: begin
                                state_q   <= S_HALT;
                                mem_req_q <= 1'b0;
                                halted_q  <= 1'b1;
                            end
                            OP_JMP, OP_BEQZ, OP_LOAD, OP_LDI, OP_STORE: begin
                                state_q    <= S_FETCH2;
                                mem_addr_q <= pc_inc;
                            end
                            default: begin
                                illegal_q  <= 1'b1;
                                mem_addr_q <= pc_inc;
                            end
                        endcase
                    end
                end
                S_FETCH2: begin
                    if (done) begin
                        state_q    <= S_FETCH1;
                        pc_q       <= pc_inc;
                        mem_addr_q <= pc_inc;
                        case (op_q)
                            OP_JMP: begin
                                pc_q       <= imm_addr;
                                mem_addr_q <= imm_addr;
                            end
                            OP_BEQZ: begin
                                pc_q       <= br_addr;
                                mem_addr_q <= br_addr;
                            end
                            OP_LDI: regs_q[rd_q] <= mem_rdata;
                            OP_LOAD: begin
                                state_q    <= S_MEMRD;
                                mem_addr_q <= imm_addr;
                            end
                            OP_STORE: begin
                                state_q     <= S_MEMWR;
                                mem_addr_q  <= imm_addr;
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= rd_val;
                            end
                            default: ;
                        endcase
                    end
                end
                S_EXEC: begin
                    regs_q[rd_q] <= alu_res;
                    state_q      <= S_FETCH1;
                    mem_req_q    <= 1'b1;
                    mem_we_q     <= 1'b0;
                    mem_addr_q   <= pc_q;
                end
                S_MEMRD: begin
                    if (done) begin
                        regs_q[rd_q] <= mem_rdata;
                        state_q      <= S_FETCH1;
                        mem_addr_q   <= pc_q;
                    end
                end
                S_MEMWR: begin
                    if (done) begin
                        state_q     <= S_FETCH1;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        mem_addr_q  <= pc_q;
                    end
                end
                S_HALT: ;
                default: state_q <= S_FETCH1;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
endmodule

// File: tb/tb_multicycle_core.sv
// Bench for multicycle_core: an instruction-level reference model predicts the
// memory transaction stream, and a monitor compares every completed access.
module tb_multicycle_core;
    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        halted;
    logic        illegal;

    logic [15:0] mem [0:65535];
    txn_t        exp_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          ill_seen = 0;
    int          ready_mode = 1;
    bit          mon_en = 0;

    multicycle_core #(.DATA_W(16), .ADDR_W(16), .NREGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .halted(halted), .illegal(illegal)
    );

    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [5:0] op, input int rd, input int rs);
        return {op, 5'(rd), 5'(rs)};
    endfunction

    task automatic put(input int a, input logic [15:0] w);
        mem[a] = w;
    endtask

    // Instruction-by-instruction interpreter; latency is the per-instruction cycle cost.
    task automatic run_model(output int lat, output int ill);
        logic [15:0] mm [512];
        logic [15:0] r [32];
        logic [15:0] pc, w, imm;
        int rd, rs;
        lat = 0; ill = 0; pc = 16'h0;
        for (int i = 0; i < 512; i++) mm[i] = mem[i];
        for (int i = 0; i < 32; i++) r[i] = 16'h0;
        for (int s = 0; s < 2000; s++) begin
            w = mm[pc[8:0]];
            exp_q.push_back(txn_t'({1'b0, pc, 16'h0}));
            pc = pc + 16'd1;
            rd = int'(w[9:5]);
            rs = int'(w[4:0]);
            if (w[15:10] == 6'b111111) begin
                lat += 1;
                break;
            end
            case (w[15:10])
                6'b000000: begin r[rd] = r[rd] & r[rs]; lat += 2; end
                6'b000001: begin r[rd] = r[rd] | r[rs]; lat += 2; end
                6'b000010: begin r[rd] = ~r[rs];        lat += 2; end
                6'b000011: begin r[rd] = r[rd] ^ r[rs]; lat += 2; end
                6'b000100: begin r[rd] = r[rd] + r[rs]; lat += 2; end
                6'b000110: begin r[rd] = r[rd] - r[rs]; lat += 2; end
                6'b100000, 6'b100001, 6'b100100, 6'b101000, 6'b101100: begin
                    imm = mm[pc[8:0]];
                    exp_q.push_back(txn_t'({1'b0, pc, 16'h0}));
                    pc = pc + 16'd1;
                    lat += 2;
                    case (w[15:10])
                        6'b100000: pc = imm;
                        6'b100001: if (r[rd] == 16'h0) pc = imm;
                        6'b101000: r[rd] = imm;
                        6'b100100: begin
                            exp_q.push_back(txn_t'({1'b0, imm, 16'h0}));
                            r[rd] = mm[imm[8:0]];
                            lat += 1;
                        end
                        default: begin
                            exp_q.push_back(txn_t'({1'b1, imm, r[rd]}));
                            mm[imm[8:0]] = r[rd];
                            lat += 1;
                        end
                    endcase
                end
                default: begin ill += 1; lat += 1; end
            endcase
        end
    endtask

    task automatic run_prog(input int mode, input bit check_cycles);
        int lat, ill, cyc;
        bit ok;
        rst_n = 1'b0;
        mon_en = 1'b0;
        exp_q.delete();
        ill_seen = 0;
        run_model(lat, ill);
        ready_mode = mode;
        repeat (2) @(posedge clk);
        #2;
        mon_en = 1'b1;
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (i == 0) begin
                chk("first_req", mem_req, 1);
                chk("first_addr", mem_addr, 0);
            end
            if (halted) break;
        end
        chk("halted", halted, 1);
        if (check_cycles) chk("cycles", cyc, lat + 1);
        ok = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (mem_req || !halted) ok = 1'b0;
        end
        chk("halt_hold", ok, 1);
        chk("sb_left", exp_q.size(), 0);
        chk("illegal_cnt", ill_seen, ill);
    endtask

    task automatic gen_random();
        int kind[$];
        int adr[$];
        int a = 0;
        int n;
        int j;
        int fs = 0;
        logic [5:0] alu_ops [6] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000110};
        logic [5:0] ill_ops [4] = '{6'b000101, 6'b010101, 6'b111110, 6'b100010};
        logic [15:0] imm;
        n = $urandom_range(15, 40);
        for (int i = 0; i < 512; i++) mem[i] = 16'h0;
        for (int i = 256; i < 272; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < n + 9; i++) begin
            int k;
            if (i < n) k = $urandom_range(0, 11);
            else if (i < n + 8) k = 13;
            else k = 14;
            kind.push_back(k);
            adr.push_back(a);
            a += (k >= 7 && k != 14) ? 2 : 1;
        end
        for (int i = 0; i < kind.size(); i++) begin
            int k = kind[i];
            int rd = $urandom_range(0, 31);
            int rs = $urandom_range(0, 31);
            if (k <= 5) put(adr[i], enc(alu_ops[k], rd, rs));
            else if (k == 6) put(adr[i], enc(ill_ops[$urandom_range(0, 3)], rd, rs));
            else if (k == 7 || k == 8) begin
                j = $urandom_range(i + 1, kind.size() - 1);
                put(adr[i], enc((k == 7) ? 6'b100000 : 6'b100001, $urandom_range(0, 3), rs));
                put(adr[i] + 1, 16'(adr[j]));
            end else if (k == 9) begin
                imm = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
                put(adr[i], enc(6'b101000, rd, rs));
                put(adr[i] + 1, imm);
            end else if (k == 10 || k == 11) begin
                put(adr[i], enc((k == 10) ? 6'b100100 : 6'b101100, rd, rs));
                put(adr[i] + 1, 16'h0100 + 16'($urandom_range(0, 15)));
            end else if (k == 13) begin
                put(adr[i], enc(6'b101100, fs, 0));
                put(adr[i] + 1, 16'h0100 + 16'(fs));
                fs++;
            end else put(adr[i], enc(6'b111111, 0, 0));
        end
    endtask

    // Monitor: stall stability, illegal pulses, and scoreboard pop on each completed access.
    initial begin
        txn_t t;
        bit stall_prev = 1'b0;
        logic [15:0] p_addr, p_wdata;
        logic p_we;
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                if (stall_prev) begin
                    chk("hold_addr", mem_addr, p_addr);
                    chk("hold_we", mem_we, p_we);
                    chk("hold_wdata", mem_wdata, p_wdata);
                end
                if (illegal) ill_seen++;
            end
            case (ready_mode)
                0:       mem_ready = ($urandom_range(0, 2) != 0);
                1:       mem_ready = 1'b1;
                default: mem_ready = !mem_we;
            endcase
            if (rst_n && mon_en && mem_req && mem_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_extra: unexpected access we=%0b addr=%h wdata=%h, expected none",
                             mem_we, mem_addr, mem_wdata);
                end else begin
                    t = exp_q.pop_front();
                    chk("txn_we", mem_we, t.we);
                    chk("txn_addr", mem_addr, t.addr);
                    chk("txn_wdata", mem_wdata, t.wdata);
                end
                if (mem_we) mem[mem_addr] = mem_wdata;
            end
            stall_prev = rst_n && mem_req && !mem_ready;
            p_addr = mem_addr;
            p_we = mem_we;
            p_wdata = mem_wdata;
        end
    end

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);

        // ALU, load/store, both branch outcomes, an illegal opcode, then HALT.
        put(0, enc(6'b101000, 1, 0));  put(1, 16'd5);
        put(2, enc(6'b101000, 2, 0));  put(3, 16'd7);
        put(4, enc(6'b000100, 1, 2));
        put(5, enc(6'b101100, 1, 0));  put(6, 16'h0040);
        put(7, enc(6'b100100, 3, 0));  put(8, 16'h0040);
        put(9, enc(6'b000110, 2, 1));
        put(10, enc(6'b101100, 2, 0)); put(11, 16'h0041);
        put(12, enc(6'b101100, 3, 0)); put(13, 16'h0042);
        put(14, enc(6'b100001, 0, 0)); put(15, 16'h0010);
        put(16, enc(6'b010101, 0, 0));
        put(17, enc(6'b101000, 0, 0)); put(18, 16'd1);
        put(19, enc(6'b100001, 0, 0)); put(20, 16'h0030);
        put(21, enc(6'b111111, 0, 0));
        run_prog(1, 1'b1);
        chk("store_r1", mem[16'h0040], 16'd12);
        chk("store_r2", mem[16'h0041], 16'hFFFB);
        chk("store_r3", mem[16'h0042], 16'd12);

        // Reset while a store is stalled.
        for (int i = 0; i < 512; i++) mem[i] = 16'h0;
        put(0, enc(6'b101000, 1, 0)); put(1, 16'h1234);
        put(2, enc(6'b101100, 1, 0)); put(3, 16'h0050);
        put(4, enc(6'b111111, 0, 0));
        rst_n = 1'b0;
        mon_en = 1'b0;
        ready_mode = 2;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (mem_req && mem_we) break;
        end
        chk("memwr_seen", mem_req & mem_we, 1);
        chk("memwr_data", mem_wdata, 16'h1234);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_req", mem_req, 0);
        chk("abort_we", mem_we, 0);
        chk("abort_wdata", mem_wdata, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        ready_mode = 1;
        @(posedge clk);
        #1;
        chk("rel_req", mem_req, 1);
        chk("rel_addr", mem_addr, 0);
        chk("rel_we", mem_we, 0);

        gen_random();
        run_prog(1, 1'b1);
        for (int p = 0; p < 6; p++) begin
            gen_random();
            run_prog(0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
